mcu_bus_ctrl: RTL

- Slave-side sequencer for the MCU parallel bus (mcu_mstr / write_enable / address / data, fpga_ready / fpga_ack handshake).
- Synchronises the asynchronous MCU strobe and captures the transaction.
- Writes output-pin bank registers or reads input-pin bank registers.
- Completes a four-phase handshake with the MCU, with release timeout.
- Sits between the MCU pins and the io-pin bank storage (17 banks x 8 bits covering io_pins[131:0]).

---
 rtl/mcu_bus_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/mcu_bus_ctrl.sv
// mcu_bus_ctrl: slave-side sequencer for the MCU parallel bus.
// Synchronises the MCU strobe, performs one bank access and a four-phase ack handshake.
module mcu_bus_ctrl #(
    parameter int unsigned NUM_BANKS   = 17,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic       CLK50,
    input  logic       rst_n,
    input  logic       mcu_mstr,
    input  logic       write_enable,
    input  logic [4:0] address,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       fpga_ready,
    output logic       fpga_ack,
    output logic       bank_wr_en,
    output logic [4:0] bank_wr_addr,
    output logic [7:0] bank_wr_data,
    output logic [4:0] bank_rd_addr,
    input  logic [7:0] bank_rd_data,
    output logic       addr_err,
    output logic       timeout
);
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ACK  = 2'd2
    } state_e;

    // Reset asserts asynchronously and is released on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge CLK50 or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_int_n = rst_sync_q[1];

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   prev_q;
    logic                   armed_q, armed_d;
    logic                   synced;
    logic                   fill_done;
    logic                   start;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  cap_addr_q, cap_addr_d;
    logic               cap_we_q, cap_we_d;
    logic [DATA_W-1:0]  cap_data_q, cap_data_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic               ack_q, ack_d;
    logic               oe_q, oe_d;
    logic               ready_q, ready_d;
    logic               err_q, err_d;
    logic               tmo_q, tmo_d;
    logic               addr_ok;
    logic               expired;

    assign synced    = sync_q[SYNC_STAGES-1];
    assign fill_done = fill_q[SYNC_STAGES-1];
    // A strobe level present at reset must go low once before it can start anything.
    assign armed_d   = armed_q | (fill_done & ~synced);
    assign start     = synced & ~prev_q & armed_q;
    assign addr_ok   = 32'(cap_addr_q) < NUM_BANKS;
    assign expired   = cnt_q == CNT_W'(ACK_TIMEOUT);

    always_ff @(posedge CLK50 or negedge rst_int_n) begin
        if (!rst_int_n) begin
            sync_q  <= '0;
            fill_q  <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], mcu_mstr};
            fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            prev_q  <= synced;
            armed_q <= armed_d;
        end
    end

    always_ff @(posedge CLK50 or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cap_addr_q <= '0;
            cap_we_q   <= 1'b0;
            cap_data_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_data_q  <= '0;
            ack_q      <= 1'b0;
            oe_q       <= 1'b0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cap_addr_q <= cap_addr_d;
            cap_we_q   <= cap_we_d;
            cap_data_q <= cap_data_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_data_q  <= rd_data_d;
            ack_q      <= ack_d;
            oe_q       <= oe_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
        end
    end

    // Next state and registered-output values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cap_addr_d = cap_addr_q;
        cap_we_d   = cap_we_q;
        cap_data_d = cap_data_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rd_data_d  = rd_data_q;
        ack_d      = 1'b0;
        oe_d       = 1'b0;
        err_d      = 1'b0;
        tmo_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cap_addr_d = address;
                    cap_we_d   = write_enable;
                    cap_data_d = data_in;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                cnt_d   = '0;
                state_d = ACK;
                if (!addr_ok) begin
                    err_d = 1'b1;
                    if (!cap_we_q) rd_data_d = 8'hFF;
                end else if (cap_we_q) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cap_addr_q;
                    wr_data_d = cap_data_q;
                end else begin
                    rd_data_d = bank_rd_data;
                end
            end
            ACK: begin
                if (!synced) begin
                    ack_d   = 1'b1;
                    state_d = IDLE;
                end else if (expired) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    ack_d = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
                oe_d = ack_d & ~cap_we_q;
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_q == IDLE) && !synced && fill_done;
    end

    assign data_out     = rd_data_q;
    assign data_oe      = oe_q;
    assign fpga_ready   = ready_q;
    assign fpga_ack     = ack_q;
    assign bank_wr_en   = wr_en_q;
    assign bank_wr_addr = wr_addr_q;
    assign bank_wr_data = wr_data_q;
    assign bank_rd_addr = cap_addr_q;
    assign addr_err     = err_q;
    assign timeout      = tmo_q;

endmodule
